// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings and defaults for the BRAM port B arbiter.
package dmem_port_arbiter_pkg;

  typedef enum logic {
    PH_BOOT = 1'b0,
    PH_RUN  = 1'b1
  } phase_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between MEM stage, loader, BRAM port B and the arbiter.
interface dmem_port_if;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_hold;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dbg_req;
  logic [3:0]  dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_done;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic [3:0]  web;
  logic [31:0] addrb;
  logic [31:0] dib;
  logic [31:0] dob;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_hold, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_done,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output web, addrb, dib,
    input  dob
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_hold, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_done,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  web, addrb, dib,
    output dob
  );
endinterface

// File: rtl/dmem_port_arbiter_rr_starve_ctr.sv
// Saturating count of CPU wins over a waiting loader; flags when the loader
// must be given the next slot.
module rr_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic dbg_req,
  input  logic dbg_gnt,
  input  logic cpu_gnt,
  output logic force_dbg
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!run || dbg_gnt || !dbg_req) begin
      starve_cnt <= '0;
    end else if (cpu_gnt && starve_cnt != LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_dbg = run && (starve_cnt == LIM);

endmodule

// File: rtl/dmem_port_arbiter.sv
// BRAM port B arbiter: loader-only BOOT phase, then CPU-priority RUN phase
// with a starvation guarantee for the loader.
//
// state   | meaning
// PH_BOOT | core held, only the loader reaches memory
// PH_RUN  | CPU has priority, loader forced in after STARVE_LIMIT CPU wins
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_port_if.slave  bus
);

  localparam phase_e RESET_PHASE = BOOT_ON_RESET ? PH_BOOT : PH_RUN;

  phase_e      phase;
  owner_e      rd_owner;
  logic        rd_pend;
  logic        cpu_hold_q;
  logic        in_boot;
  logic        force_dbg;
  logic        cpu_gnt;
  logic        dbg_gnt;
  logic        rd_start;
  logic        cpu_rvalid;
  logic        dbg_rvalid;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dbg_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= RESET_PHASE;
      cpu_hold_q <= BOOT_ON_RESET;
    end else begin
      case (phase)
        PH_BOOT: begin
          if (bus.dbg_done) begin
            phase      <= PH_RUN;
            cpu_hold_q <= 1'b0;
          end
        end
        PH_RUN: begin
          cpu_hold_q <= 1'b0;
        end
        default: begin
          phase      <= RESET_PHASE;
          cpu_hold_q <= BOOT_ON_RESET;
        end
      endcase
    end
  end

  assign in_boot = (phase == PH_BOOT);

  rr_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (!in_boot),
    .dbg_req   (bus.dbg_req),
    .dbg_gnt   (dbg_gnt),
    .cpu_gnt   (cpu_gnt),
    .force_dbg (force_dbg)
  );

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (in_boot) begin
      dbg_gnt = bus.dbg_req;
    end else if (bus.cpu_req && bus.dbg_req) begin
      dbg_gnt = force_dbg;
      cpu_gnt = !force_dbg;
    end else begin
      cpu_gnt = bus.cpu_req;
      dbg_gnt = bus.dbg_req;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.cpu_stall = (bus.cpu_req && !cpu_gnt) || in_boot;
  assign bus.cpu_hold  = cpu_hold_q;

  // Idle cycles keep address/data stable so the BRAM pins do not toggle.
  assign bus.web   = cpu_gnt ? bus.cpu_we    : (dbg_gnt ? bus.dbg_we    : 4'h0);
  assign bus.addrb = cpu_gnt ? bus.cpu_addr  : (dbg_gnt ? bus.dbg_addr  : addr_q);
  assign bus.dib   = cpu_gnt ? bus.cpu_wdata : (dbg_gnt ? bus.dbg_wdata : wdata_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (cpu_gnt || dbg_gnt) begin
      addr_q  <= bus.addrb;
      wdata_q <= bus.dib;
    end
  end

  assign rd_start = (cpu_gnt && bus.cpu_we == 4'h0) ||
                    (dbg_gnt && bus.dbg_we == 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend <= rd_start;
      if (rd_start) begin
        rd_owner <= cpu_gnt ? OWN_CPU : OWN_DBG;
      end
    end
  end

  assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
  assign dbg_rvalid = rd_pend && (rd_owner == OWN_DBG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= bus.dob;
      if (dbg_rvalid) dbg_rdata_q <= bus.dob;
    end
  end

  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.dob : cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rvalid ? bus.dob : dbg_rdata_q;

endmodule
